// File: rtl/fft_bank_sched.sv
`timescale 1ns/1ps
// Ownership sequencer for the 2D FFT BRAM bank: hands the bank from the MicroBlaze
// to the FFT core for a row pass and a column pass, with guard gaps on each handoff.
module fft_bank_sched #(
  parameter int unsigned GUARD   = 2,
  parameter int unsigned TO_W    = 20,
  parameter int unsigned TIMEOUT = (2**TO_W) - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic mb_start,
  input  logic mb_inverse,
  output logic MB_is_acting,
  output logic FFT_en,
  output logic core_start,
  output logic core_pass,
  output logic core_inverse,
  input  logic core_done,
  output logic busy,
  output logic done,
  output logic error
);

  typedef enum logic [2:0] {
    MB_OWN   = 3'd0,
    G_IN     = 3'd1,
    ROW_WAIT = 3'd2,
    COL_WAIT = 3'd3,
    G_OUT    = 3'd4
  } state_t;

  localparam logic [3:0]      GUARD_LOAD = 4'(GUARD - 1);
  localparam logic [TO_W-1:0] WD_LAST    = TO_W'(TIMEOUT - 1);

  state_t          state_q;
  logic [3:0]      guard_q;
  logic [TO_W-1:0] wd_q;
  logic            mb_q, fft_q, cstart_q, cpass_q, cinv_q, busy_q, done_q, err_q;

  // A done pulse coinciding with our own start pulse belongs to nobody's pass.
  logic done_ok, wd_expired;
  assign done_ok    = core_done && !cstart_q;
  assign wd_expired = (wd_q == WD_LAST);

  // NOTE: every state bit is updated with <= in one clocked block, so all outputs
  // are registers and the reset branch returns the bank to the MicroBlaze at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MB_OWN;
      guard_q  <= '0;
      wd_q     <= '0;
      mb_q     <= 1'b1;
      fft_q    <= 1'b0;
      cstart_q <= 1'b0;
      cpass_q  <= 1'b0;
      cinv_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cstart_q <= 1'b0;
      case (state_q)
        MB_OWN: begin
          if (mb_start) begin
            cinv_q  <= mb_inverse;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            guard_q <= GUARD_LOAD;
            mb_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= G_IN;
          end
        end
        G_IN: begin
          if (guard_q == 4'd0) begin
            cstart_q <= 1'b1;
            cpass_q  <= 1'b0;
            fft_q    <= 1'b1;
            wd_q     <= '0;
            state_q  <= ROW_WAIT;
          end else begin
            guard_q <= guard_q - 4'd1;
          end
        end
        ROW_WAIT: begin
          if (done_ok) begin
            cstart_q <= 1'b1;
            cpass_q  <= 1'b1;
            wd_q     <= '0;
            state_q  <= COL_WAIT;
          end else if (wd_expired) begin
            err_q   <= 1'b1;
            fft_q   <= 1'b0;
            cpass_q <= 1'b0;
            guard_q <= GUARD_LOAD;
            state_q <= G_OUT;
          end else begin
            wd_q <= wd_q + TO_W'(1);
          end
        end
        COL_WAIT: begin
          // A completion on the expiry cycle wins over the abort.
          if (done_ok || wd_expired) begin
            err_q   <= !done_ok;
            fft_q   <= 1'b0;
            cpass_q <= 1'b0;
            guard_q <= GUARD_LOAD;
            state_q <= G_OUT;
          end else begin
            wd_q <= wd_q + TO_W'(1);
          end
        end
        G_OUT: begin
          if (guard_q == 4'd0) begin
            mb_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= MB_OWN;
          end else begin
            guard_q <= guard_q - 4'd1;
          end
        end
        default: state_q <= MB_OWN;
      endcase
    end
  end

  assign MB_is_acting = mb_q;
  assign FFT_en       = fft_q;
  assign core_start   = cstart_q;
  assign core_pass    = cpass_q;
  assign core_inverse = cinv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;

endmodule

// File: doc/fft_bank_sched.md
# fft_bank_sched

Sequencer for the 2D FFT BRAM bank (32 dual-port BRAMs, 64 rows × 16-bit words). It owns the single `MB_is_acting` ownership bit and hands the bank back and forth between the MicroBlaze and the FFT core. On one start command it runs a full 2D transform: a row pass, then a column pass, forward or inverse. Guard cycles between owners prevent contention on the tristate data ports.

## Interface

**Parameters**
- `GUARD`, default 2: idle cycles between ownership changes, during which neither side drives. Legal range is 1..15.
- `TO_W`, default 20: width of the watchdog counter.
- `TIMEOUT`, default 2^20-1: maximum cycles allowed in one pass wait before abort. Legal range is 2..2^TO_W-1.

**Ports**
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mb_start` in 1: one-cycle start command from the MicroBlaze register.
- `mb_inverse` in 1: transform direction, sampled with `mb_start`. 1 selects IFFT.
- `MB_is_acting` out 1: 1 when the MicroBlaze owns the bank.
- `FFT_en` out 1: core owns the bank. It is ANDed externally into `FFT_wea`, `FFT_web`, `FFT_rea` and `FFT_reb`.
- `core_start` out 1: one-cycle pass start to the FFT core.
- `core_pass` out 1: 0 = row pass, 1 = column pass. Valid while `FFT_en` is 1.
- `core_inverse` out 1: latched `mb_inverse`.
- `core_done` in 1: one-cycle pass-complete pulse from the core.
- `busy` out 1: transform in progress, including both guard phases.
- `done` out 1: sticky. Set at the end of a transform; cleared by the next accepted start.
- `error` out 1: sticky. Set on watchdog abort; cleared by the next accepted start.

## Operation

**States:** `MB_OWN`, `G_IN`, `ROW_WAIT`, `COL_WAIT`, `G_OUT`.
- **`MB_OWN`**
  - Outputs: `MB_is_acting`=1, `FFT_en`=0, `busy`=0.
  - On `mb_start`=1: latch `core_inverse`, clear `done` and `error`, load the guard counter, and go to `G_IN`.
- **`G_IN`**
  - `MB_is_acting`=0, `FFT_en`=0, `busy`=1.
  - Count GUARD cycles.
  - On exit: assert `core_start`=1 with `core_pass`=0, set `FFT_en`=1, clear the watchdog, and go to `ROW_WAIT`.
- **`ROW_WAIT`**
  - On `core_done`: pulse `core_start` with `core_pass`=1, clear the watchdog, and go to `COL_WAIT`. `FFT_en` stays 1 with no gap.
- **`COL_WAIT`**
  - On `core_done`: set `FFT_en`=0, load the guard counter, and go to `G_OUT`.
- **`G_OUT`**
  - `MB_is_acting`=0, `FFT_en`=0.
  - After GUARD cycles: set `MB_is_acting`=1, `done`=1, `busy`=0, and go to `MB_OWN`.
- **Watchdog**
  - Increments every cycle in `ROW_WAIT` or `COL_WAIT`.
  - When it reaches TIMEOUT-1 with no `core_done`: set `error`=1 and take the same exit as a `COL_WAIT` completion (`G_OUT`, then `done`=1).
- **Ignored inputs**
  - `mb_start` in any state other than `MB_OWN` is ignored; `core_inverse` does not change.
  - `core_done` outside `ROW_WAIT`/`COL_WAIT`, or in the same cycle as `core_start`, is ignored.
- **Simultaneous events:** `core_done` in the cycle the watchdog expires counts as a completion; `error` stays 0.
- **Ownership invariant:** `MB_is_acting` and `FFT_en` are never 1 together and are registered outputs, so there are no glitches.

## Timing

- **Reset values:** `MB_is_acting`=1; `FFT_en`, `core_start`, `core_pass`, `core_inverse`, `busy`, `done`, `error` = 0; state = `MB_OWN`.
- **Reset asserted mid-transform:** all outputs take their reset values immediately, so the bank returns to the MicroBlaze without a guard.
- **Start sequence,** with `mb_start` sampled at edge t:
  - t+1: `MB_is_acting`=0, `busy`=1.
  - t+1+GUARD: `FFT_en`=1 and `core_start`=1 (row pass).
- **Row-to-column handoff:** `core_done` sampled at edge d gives `core_start`=1 with `core_pass`=1 at d+1.
- **End sequence,** with the final `core_done` sampled at edge e:
  - e+1: `FFT_en`=0.
  - e+1+GUARD: `MB_is_acting`=1, `done`=1, `busy`=0.
- **Scheduler overhead:** 2·GUARD+3 cycles beyond core compute time.
- **Back-to-back transforms:** `mb_start` is accepted in the first `MB_OWN` cycle after `done` rises.

## Test plan

- **Reset:** assert `rst` → `MB_is_acting`=1 and all other outputs 0. Assert `rst` mid-`ROW_WAIT` → `MB_is_acting`=1 and `FFT_en`=0 in the same cycle.
- **Nominal forward:** GUARD=2, `mb_start` at cycle 10, `core_done` at cycles 100 and 200 →
  - `MB_is_acting` falls at 11.
  - `core_start` at 13 (pass 0) and 101 (pass 1).
  - `FFT_en` spans 13..200.
  - `done` and `MB_is_acting` rise at 203.
- **Inverse plus ignored start:** `mb_inverse`=1 with start, then `mb_start` with `mb_inverse`=0 during `ROW_WAIT` → `core_inverse` stays 1, no restart, identical cycle counts.
- **Watchdog:** TIMEOUT=16, core never responds →
  - `error`=1 after 16 cycles in `ROW_WAIT`.
  - No column pass.
  - `MB_is_acting`=1 after GUARD+1 more cycles; `done`=1.
  - The next start clears `error` and `done`.
- **Boundary:**
  - `core_done` in the `core_start` cycle → ignored; the pass waits for a later `done`.
  - `core_done` in the expiry cycle → `error`=0.
  - With GUARD=1, the ownership invariant is checked by assertion on every cycle.
